// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU bus-cycle sequencer: bus operations and T-state phases.
package cpu_bus_pkg;

  typedef logic [1:0] bus_op_t;

  localparam bus_op_t BUS_IDLE  = 2'b00;
  localparam bus_op_t BUS_FETCH = 2'b01;
  localparam bus_op_t BUS_WRITE = 2'b10;
  localparam bus_op_t BUS_READ  = 2'b11;

  typedef enum logic [1:0] {
    PH_T0,
    PH_HOLD,
    PH_DATA,
    PH_END
  } ct_phase_t;

endpackage

// File: rtl/cpu_wait_timer.sv
// Saturating stall counter; expire rises once WAIT_MAX stall clocks have been counted.
module cpu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic step,
  output logic expire
);

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] cnt;

  // load marks the first stall clock, so counting starts at one
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1);
    end else if (step && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LIMIT);

endmodule

// File: rtl/cpu_bus_seq.sv
// Bus-cycle sequencer: splits each M-cycle into CT_N T-states and drives the external bus.
// Define CPU_BUS_WAIT_EN to add the ready input with stall/timeout handling.
module cpu_bus_seq
  import cpu_bus_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int CT_N     = 4,
  parameter int MCW      = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              bus_op,
  input  logic [AW-1:0]           ab,
  input  logic [DW-1:0]           db_wr,
  input  logic                    next,
  input  logic [DW-1:0]           din,
`ifdef CPU_BUS_WAIT_EN
  input  logic                    ready,
`endif
  output logic [AW-1:0]           a,
  output logic [DW-1:0]           dout,
  output logic                    rd,
  output logic                    wr,
  output logic                    phi,
  output logic [$clog2(CT_N)-1:0] ct,
  output logic [MCW-1:0]          m_cycle,
  output logic [DW-1:0]           opcode,
  output logic [DW-1:0]           rd_data,
  output logic                    rd_valid,
  output logic                    mc_end,
  output logic                    stall,
  output logic                    bus_err
);

  localparam int CTW = $clog2(CT_N);
  localparam logic [CTW-1:0] CT_DATA = CTW'(CT_N / 2);
  localparam logic [CTW-1:0] CT_LAST = CTW'(CT_N - 1);

  ct_phase_t phase;
  bus_op_t   op_q;
  logic      hold;

  always_comb begin
    phase = PH_HOLD;
    if (ct == '0) begin
      phase = PH_T0;
    end else if (ct == CT_DATA) begin
      phase = PH_DATA;
    end else if (ct == CT_LAST) begin
      phase = PH_END;
    end
  end

`ifdef CPU_BUS_WAIT_EN
  logic expire;
  logic wait_cond;
  logic stall_q;
  logic err_q;

  // Idle cycles have no data transfer, so they never wait on the bus
  assign wait_cond = (phase == PH_DATA) && (op_q != BUS_IDLE) && !ready;
  assign hold      = wait_cond && !expire;

  cpu_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!hold),
    .load  (hold && !stall_q),
    .step  (hold && stall_q),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= hold;
      if (wait_cond && expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign stall   = stall_q;
  assign bus_err = err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX > 0);
  assign hold    = 1'b0;
  assign stall   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // While held in the data phase every output, including rd and phi, keeps its value
  always_ff @(posedge clk) begin
    if (rst) begin
      ct       <= '0;
      op_q     <= BUS_IDLE;
      a        <= '0;
      dout     <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      phi      <= 1'b0;
      m_cycle  <= '0;
      opcode   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      mc_end   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      mc_end   <= 1'b0;
      if (!hold) begin
        ct <= (ct == CT_LAST) ? '0 : ct + 1'b1;
      end
      case (phase)
        PH_T0: begin
          a    <= ab;
          op_q <= bus_op;
          rd   <= (bus_op == BUS_FETCH) || (bus_op == BUS_READ);
          wr   <= 1'b0;
          phi  <= 1'b1;
        end
        PH_DATA: begin
          if (!hold) begin
            rd  <= 1'b0;
            phi <= 1'b0;
            case (op_q)
              BUS_WRITE: begin
                wr   <= 1'b1;
                dout <= db_wr;
              end
              BUS_FETCH: opcode <= din;
              BUS_READ: begin
                rd_data  <= din;
                rd_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        PH_END: begin
          rd      <= 1'b0;
          wr      <= 1'b0;
          dout    <= '0;
          mc_end  <= 1'b1;
          m_cycle <= next ? m_cycle + 1'b1 : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_bus_seq.md
# cpu_bus_seq

Parametrised bus-cycle sequencer for the Game Boy CPU core, the next generation of the CPU's built-in T-state (CT) machine. It sits between the control unit/datapath and the external memory bus. Each M-cycle is divided into a configurable number of T-states, and the block drives address, strobes and `phi`. It latches fetched opcodes and read data, and tracks the multi-M-cycle counter. Beyond the fixed 4-T design, it adds bus wait-states with a timeout, generic address/data widths, and a registered M-cycle counter with a completion pulse.

## Interface
Parameters:
- `AW`, 16, address width.
- `DW`, 8, data width.
- `CT_N`, 4, T-states per M-cycle; must be an even number ≥ 4.
- `MCW`, 3, M-cycle counter width.
- `WAIT_MAX`, 15, maximum stall clocks before forced completion (only used with `CPU_BUS_WAIT_EN`).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `bus_op` in 2: 00 idle, 01 fetch, 10 write, 11 read; sampled at T0.
- `ab` in AW: address for this M-cycle; sampled at T0.
- `db_wr` in DW: write data; sampled at the data phase.
- `next` in 1: control requests another M-cycle of the current instruction; sampled on the last T-state.
- `din` in DW: external read data.
- `ready` in 1: external wait-state input, active-low stall. Present only with `CPU_BUS_WAIT_EN`.
- `a` out AW: registered bus address.
- `dout` out DW: registered write data.
- `rd` out 1: read strobe.
- `wr` out 1: write strobe.
- `phi` out 1: bus phase clock.
- `ct` out $clog2(CT_N): current T-state.
- `m_cycle` out MCW: current M-cycle within the instruction.
- `opcode` out DW: last fetched opcode.
- `rd_data` out DW: last read byte.
- `rd_valid` out 1: one-clock pulse when `rd_data` updates.
- `mc_end` out 1: one-clock pulse on the last T-state.
- `stall` out 1: high while the data phase is held.
- `bus_err` out 1: sticky wait-timeout flag; cleared only by `rst`.

## Operation
- T-state counter `ct` counts 0 … CT_N−1 and wraps to 0. The data phase is defined as `D = CT_N/2`.
- **T0:** latch `a <= ab`, assert `rd` for fetch/read, set `phi <= 1`, deassert `wr`, latch `bus_op` internally.
- **T1 … D−1:** hold all outputs.
- **Data phase at T=D:**
  - Write: `wr <= 1`, `dout <= db_wr`.
  - Fetch: `opcode <= din`.
  - Read: `rd_data <= din`, `rd_valid` pulses.
  - Idle: none of the above.
  - All ops: `rd <= 0`, `phi <= 0`.
- **T=CT_N−1:**
  - `rd <= 0`, `wr <= 0`, `dout <= 0`, `mc_end` pulses.
  - `m_cycle <= next ? m_cycle+1 : 0`. Wraps modulo 2^MCW.
- `bus_op`, `ab` and `db_wr` changes outside their sample points are ignored.
- Reset values: `ct=0`, `a=0`, `dout=0`, `rd=0`, `wr=0`, `phi=0`, `opcode=0` (NOP), `rd_data=0`, `rd_valid=0`, `mc_end=0`, `m_cycle=0`, `stall=0`, `bus_err=0`.
- Reset mid-cycle aborts the cycle. All outputs take their reset values on the next edge, and the cycle restarts at T0.

## Timing
- All outputs are registered. The action listed for T=k becomes visible one clock after the edge on which `ct==k`.
- Fetch-to-opcode latency: 3 clocks from T0 for `CT_N=4`.
- Idle M-cycle: no strobes, `phi` still toggles, and `mc_end` still pulses.
- **Stall (with `CPU_BUS_WAIT_EN`):**
  - If `ready==0` when `ct==D` and `bus_op≠idle`, `ct` holds at D, the data action is deferred and `stall=1`. `rd` and `phi` stay high during the stall.
  - The action executes on the first clock with `ready==1`.
- **Timeout:**
  - Stall count saturates at `WAIT_MAX`.
  - Reaching it forces the data action: read data is taken from `din` as-is, and `bus_err` is set.
- Idle cycles never stall.

## Configuration
- `CPU_BUS_WAIT_EN` defined: `ready` port present, and stall/timeout logic is built. `bus_err` and `stall` behave as above.
- Not defined: `ready` port absent, and every M-cycle is exactly `CT_N` clocks. `stall` and `bus_err` are tied to 0.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - `BUS_IDLE`, `BUS_FETCH`, `BUS_WRITE`, `BUS_READ` encodings;
  - a `bus_op_t` typedef;
  - a `ct_phase_t` enum for T0 / hold / data / end.
- One sub-module: `cpu_wait_timer`, the saturating stall counter with load/clear/expire. It is instantiated only under `CPU_BUS_WAIT_EN`.

## Test plan
All scenarios use `CT_N=4`.
- **Fetch:** `ab=16'h0100`, `bus_op=01`, `din=8'h3E` → `a=0100` and `rd=1`, `phi=1` after T0; `opcode=3E` after T2; `rd=0` after T2; `mc_end` pulses at T3.
- **Write:** `ab=16'hC000`, `db_wr=8'h5A`, `bus_op=10` → `wr=1` and `dout=5A` after T2; `wr=0` and `dout=0` after T3; `rd` stays 0 throughout.
- **Multi-cycle count:** `next=1` for 3 M-cycles, then `next=0` → `m_cycle` goes 1, 2, 3, 0, each update coincident with the `mc_end` edge.
- **Wait states:** read with `ready=0` for 5 clocks → `ct` holds at 2, `stall=1` for 5 clocks; `rd_valid` pulses one clock after `ready` rises; M-cycle length is 9 clocks.
- **Timeout:** `WAIT_MAX=3`, `ready` held low → forced completion after 3 stall clocks, `bus_err=1` and it stays set through later cycles until `rst`.
- **Mid-cycle reset:** `rst` asserted at T2 of a write → `wr=0`, `dout=0`, `ct=0`, `m_cycle=0` next clock; the following cycle starts cleanly at T0.
